// File: rtl/obi_sram_ctrl.sv
// OBI data-port slave terminating on a single-port synchronous SRAM.
// One outstanding request, optional wait states, bad addresses answered with err_o.
module obi_sram_ctrl #(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned WAIT_STATES = 0,
  parameter logic [31:0] BASE_ADDR   = 32'h0000_0000
) (
  input  logic                           clk_i,
  input  logic                           rst_ni,
  input  logic                           req_i,
  output logic                           gnt_o,
  input  logic [31:0]                    addr_i,
  input  logic                           we_i,
  input  logic [3:0]                     be_i,
  input  logic [31:0]                    wdata_i,
  output logic                           rvalid_o,
  output logic [31:0]                    rdata_o,
  output logic                           err_o,
  output logic                           sram_cs_o,
  output logic                           sram_we_o,
  output logic [3:0]                     sram_wmask_o,
  output logic [$clog2(DEPTH_WORDS)-1:0] sram_addr_o,
  output logic [31:0]                    sram_wdata_o,
  input  logic [31:0]                    sram_rdata_i,
  output logic [1:0]                     dbg_state_o
);

  localparam int unsigned AW = $clog2(DEPTH_WORDS);
  // 33-bit bounds so BASE_ADDR + window size cannot wrap past 2^32.
  localparam logic [32:0] LO_BOUND = {1'b0, BASE_ADDR};
  localparam logic [32:0] HI_BOUND = {1'b0, BASE_ADDR} + 33'(DEPTH_WORDS) * 33'd4;
  localparam logic [3:0]  WS_LOAD  = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_RESP   = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] addr_q;
  logic        we_q;
  logic [3:0]  be_q;
  logic [31:0] wdata_q;
  logic        bad_q;

  logic        grant;
  logic        bad_in;
  logic [32:0] addr_ext;
  logic [31:0] word_off;
  logic        unused_word_off;

  assign grant    = req_i && (state_q == S_IDLE || state_q == S_RESP);
  assign gnt_o    = grant;
  assign addr_ext = {1'b0, addr_i};
  assign bad_in   = (addr_i[1:0] != 2'b00) || (addr_ext < LO_BOUND) || (addr_ext >= HI_BOUND);

  assign word_off        = (addr_q - BASE_ADDR) >> 2;
  assign unused_word_off = ^word_off;
  assign dbg_state_o     = state_q;

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= S_IDLE;
      cnt_q   <= 4'd0;
      addr_q  <= 32'd0;
      we_q    <= 1'b0;
      be_q    <= 4'd0;
      wdata_q <= 32'd0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      if (grant) begin
        addr_q  <= addr_i;
        we_q    <= we_i;
        be_q    <= be_i;
        wdata_q <= wdata_i;
        bad_q   <= bad_in;
      end
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    case (state_q)
      S_IDLE, S_RESP: begin
        if (grant) begin
          if (WAIT_STATES > 0) begin
            state_d = S_WAIT;
            cnt_d   = WS_LOAD;
          end else begin
            state_d = S_ACCESS;
          end
        end else if (state_q == S_RESP) begin
          state_d = S_IDLE;
        end
      end
      S_WAIT: begin
        if (cnt_q == 4'd0) state_d = S_ACCESS;
        else               cnt_d   = cnt_q - 4'd1;
      end
      S_ACCESS: state_d = S_RESP;
      default:  state_d = S_IDLE;
    endcase
  end

  // Bad requests still walk through ACCESS so errors keep normal latency.
  always_comb begin
    sram_cs_o    = 1'b0;
    sram_we_o    = 1'b0;
    sram_wmask_o = 4'd0;
    sram_addr_o  = '0;
    sram_wdata_o = 32'd0;
    rvalid_o     = 1'b0;
    err_o        = 1'b0;
    rdata_o      = 32'd0;
    if (state_q == S_ACCESS) begin
      sram_cs_o    = !bad_q;
      sram_we_o    = we_q && !bad_q;
      sram_wmask_o = (we_q && !bad_q) ? be_q : 4'd0;
      sram_addr_o  = word_off[AW-1:0];
      sram_wdata_o = wdata_q;
    end
    if (state_q == S_RESP) begin
      rvalid_o = 1'b1;
      err_o    = bad_q;
      rdata_o  = (!we_q && !bad_q) ? sram_rdata_i : 32'd0;
    end
  end

endmodule
